wb_boot_copy: RTL and testbench
===============================

Name: wb_boot_copy

Overview:
- Wishbone master that copies a boot image from the on-chip ROM slave into RAM after reset, then releases the CPU.
- Sits directly upstream of the ROM slave: drives its cyc/stb/adr and consumes its dat/ack.
- Its RAM-side master port feeds the main-memory Wishbone slave.
- Holds the CPU in reset (cpu_hold_o) until the copy completes.

Parameters:
- WORDS, 1024, number of 32-bit words to copy (>=1, <= 2**SRC_AW).
- SRC_AW, $clog2(WORDS), ROM word-address width.
- DST_AW, 32, RAM byte-address width.
- DST_BASE, 32'h0000_0000, RAM byte address of the first word (4-byte aligned).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  level; begin copy when high in IDLE.
- busy_o  out  1  high in RD/WR states.
- done_o  out  1  copy finished; sticky until reset.
- cpu_hold_o  out  1  high from reset until done_o.
- rom_cyc_o  out  1  ROM cycle.
- rom_stb_o  out  1  ROM strobe.
- rom_adr_o  out  SRC_AW  ROM word address.
- rom_dat_i  in  32  ROM read data, valid when rom_ack_i.
- rom_ack_i  in  1  ROM acknowledge.
- ram_cyc_o  out  1  RAM cycle.
- ram_stb_o  out  1  RAM strobe.
- ram_we_o  out  1  RAM write enable (1 whenever ram_stb_o).
- ram_adr_o  out  DST_AW  RAM byte address.
- ram_dat_o  out  32  RAM write data.
- ram_sel_o  out  4  byte selects, 4'hF during writes.
- ram_ack_i  in  1  RAM acknowledge.

Behaviour:
- Reset (async on rst_n low, any state): state=IDLE, cnt=0, data reg=0.
  - All cyc/stb/we = 0; rom_adr_o=0, ram_adr_o=DST_BASE, ram_dat_o=0, ram_sel_o=0.
  - busy_o=0, done_o=0, cpu_hold_o=1.
- Reset mid-copy aborts immediately; strobes drop asynchronously; a later start_i restarts from word 0.
- All outputs are registered. cnt is $clog2(WORDS+1) bits wide.
- IDLE: if start_i=1 at an edge, go to RD with cnt=0; rom_cyc_o/rom_stb_o rise at that edge.
- RD: rom_cyc_o=rom_stb_o=1, rom_adr_o=cnt.
  - On an edge with rom_ack_i=1: latch rom_dat_i into ram_dat_o, drop rom_cyc/stb at the same edge, go to WR.
  - Strobes are never held through the ack edge. The ROM acks one cycle after stb and self-clears, so each read costs exactly 2 cycles.
- WR: ram_cyc_o=ram_stb_o=ram_we_o=1, ram_sel_o=4'hF, ram_adr_o=DST_BASE+(cnt<<2), truncated to DST_AW (wraps).
  - Wait indefinitely for ram_ack_i. On ack, drop RAM strobes at the same edge.
  - If cnt==WORDS-1: go to DONE. Otherwise cnt<=cnt+1 and go to RD.
- There is never a cycle with both ROM and RAM strobes high, nor a gap cycle between an ack and the next strobe.
- DONE: done_o=1, cpu_hold_o=0, busy_o=0, all strobes 0. start_i is ignored. Only reset leaves DONE.
- Stray acks: rom_ack_i outside RD and ram_ack_i outside WR are ignored.
- start_i changes while busy are ignored.
- Total latency with a 1-cycle-ack RAM: start edge to done_o = 4*WORDS cycles.

Test Plan:
- WORDS=4, ROM={11111111,22222222,33333333,44444444}, RAM acks 1 cycle after stb, start_i pulse -> RAM writes to 0x0,0x4,0x8,0xC with those data, sel=F; done_o rises 16 cycles after start edge; cpu_hold_o falls with done_o.
- DST_BASE=0x8000_0000, WORDS=2 -> write addresses 0x8000_0000 and 0x8000_0004.
- RAM ack delayed 5 cycles on word 1 -> ram_stb_o held steady with unchanged adr/dat until ack; no ROM strobe meanwhile; done_o still correct.
- Assert rst_n low while in WR of word 2 -> all strobes 0 and cpu_hold_o=1 immediately; re-start copies from ROM address 0.
- Spurious rom_ack_i and ram_ack_i pulses in IDLE and DONE, plus start_i high in DONE -> no bus activity, done_o stays 1.
- Protocol checker throughout: rom_stb_o never high on the cycle after rom_ack_i; ROM and RAM strobes never both high.

Source files
------------

// File: rtl/wb_boot_copy.sv
// Boot copier: reads WORDS words from the ROM Wishbone slave and writes them to RAM,
// holding the CPU in reset until the whole image has landed.
module wb_boot_copy #(
  parameter int                WORDS    = 1024,
  parameter int                SRC_AW   = $clog2(WORDS),
  parameter int                DST_AW   = 32,
  parameter logic [DST_AW-1:0] DST_BASE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cpu_hold_o,
  output logic              rom_cyc_o,
  output logic              rom_stb_o,
  output logic [SRC_AW-1:0] rom_adr_o,
  input  logic [31:0]       rom_dat_i,
  input  logic              rom_ack_i,
  output logic              ram_cyc_o,
  output logic              ram_stb_o,
  output logic              ram_we_o,
  output logic [DST_AW-1:0] ram_adr_o,
  output logic [31:0]       ram_dat_o,
  output logic [3:0]        ram_sel_o,
  input  logic              ram_ack_i
);

  localparam int CW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n, cnt_inc;
  logic                rom_stb_n, ram_stb_n, busy_n, done_n;
  logic [SRC_AW-1:0]   rom_adr_n;
  logic [DST_AW-1:0]   ram_adr_n;
  logic [31:0]         ram_dat_n;
  logic [3:0]          ram_sel_n;

  // cyc/we always track their strobe, and hold is simply "not yet done",
  // so every output still comes straight off a flop.
  assign rom_cyc_o  = rom_stb_o;
  assign ram_cyc_o  = ram_stb_o;
  assign ram_we_o   = ram_stb_o;
  assign cpu_hold_o = ~done_o;
  assign cnt_inc    = cnt + CW'(1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rom_stb_n = rom_stb_o;
    rom_adr_n = rom_adr_o;
    ram_stb_n = ram_stb_o;
    ram_adr_n = ram_adr_o;
    ram_dat_n = ram_dat_o;
    ram_sel_n = ram_sel_o;
    done_n    = done_o;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n   = S_RD;
          cnt_n     = '0;
          rom_stb_n = 1'b1;
          rom_adr_n = '0;
        end
      end
      S_RD: begin
        // Hand straight over to the RAM write on the ack edge: no idle cycle.
        if (rom_ack_i) begin
          state_n   = S_WR;
          rom_stb_n = 1'b0;
          ram_stb_n = 1'b1;
          ram_dat_n = rom_dat_i;
          ram_sel_n = 4'hF;
          ram_adr_n = DST_BASE + (DST_AW'(cnt) << 2);
        end
      end
      S_WR: begin
        if (ram_ack_i) begin
          ram_stb_n = 1'b0;
          ram_sel_n = 4'h0;
          if (cnt == CW'(WORDS - 1)) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = S_RD;
            cnt_n     = cnt_inc;
            rom_stb_n = 1'b1;
            rom_adr_n = cnt_inc[SRC_AW-1:0];
          end
        end
      end
      default: ;
    endcase
    busy_n = (state_n == S_RD) || (state_n == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rom_stb_o <= 1'b0;
      rom_adr_o <= '0;
      ram_stb_o <= 1'b0;
      ram_adr_o <= DST_BASE;
      ram_dat_o <= '0;
      ram_sel_o <= 4'h0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rom_stb_o <= rom_stb_n;
      rom_adr_o <= rom_adr_n;
      ram_stb_o <= ram_stb_n;
      ram_adr_o <= ram_adr_n;
      ram_dat_o <= ram_dat_n;
      ram_sel_o <= ram_sel_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
    end
  end

endmodule

// File: tb/tb_wb_boot_copy.sv
// Bench for wb_boot_copy: two instances (4 words at 0x0, 2 words at 0x8000_0000) with
// ROM/RAM slave models, a copy-list reference model and a scoreboard monitor.
module tb_wb_boot_copy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, spur_rom, spur_ram;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] rom_mem [4];
  int          ram_dly [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Cycles for a w-word copy: 2 per ROM read, 1 + ack delay per RAM write.
  function automatic int lat_of(input int w);
    int s = 0;
    for (int i = 0; i < w; i++) s += 3 + ram_dly[i];
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int          W    = (g == 0) ? 4 : 2;
    localparam int          AW   = $clog2(W);
    localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'h8000_0000;

    logic          rom_cyc, rom_stb, rom_ack, rom_ack_r;
    logic [AW-1:0] rom_adr;
    logic [31:0]   rom_dat;
    logic          ram_cyc, ram_stb, ram_we, ram_ack, ram_ack_r;
    logic [31:0]   ram_adr, ram_dat;
    logic [3:0]    ram_sel;
    logic          busy, done, hold;
    int            wcnt, wi;

    wb_boot_copy #(.WORDS(W), .SRC_AW(AW), .DST_AW(32), .DST_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .busy_o(busy), .done_o(done), .cpu_hold_o(hold),
      .rom_cyc_o(rom_cyc), .rom_stb_o(rom_stb), .rom_adr_o(rom_adr),
      .rom_dat_i(rom_dat), .rom_ack_i(rom_ack),
      .ram_cyc_o(ram_cyc), .ram_stb_o(ram_stb), .ram_we_o(ram_we),
      .ram_adr_o(ram_adr), .ram_dat_o(ram_dat), .ram_sel_o(ram_sel),
      .ram_ack_i(ram_ack)
    );

    assign rom_ack = rom_ack_r | spur_rom;
    assign ram_ack = ram_ack_r | spur_ram;
    assign wi      = int'((ram_adr - BASE) >> 2) & 3;

    // ROM slave: single-cycle registered ack, junk data when not addressed
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rom_ack_r <= 1'b0;
        rom_dat   <= '0;
      end else begin
        rom_ack_r <= rom_stb & ~rom_ack_r;
        rom_dat   <= rom_stb ? rom_mem[int'(rom_adr)] : $urandom;
      end
    end

    // RAM slave: acks ram_dly[word] cycles after the strobe rises
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ram_ack_r <= 1'b0;
        wcnt      <= 0;
      end else if (ram_stb && !ram_ack_r) begin
        if (wcnt + 1 >= ram_dly[wi]) begin
          ram_ack_r <= 1'b1;
          wcnt      <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        ram_ack_r <= 1'b0;
        wcnt      <= 0;
      end
    end

    // Reference model: a start accepted before any copy queues the whole write list
    logic [31:0] ea_q[$];
    logic [31:0] ed_q[$];
    int          er_q[$];
    bit          started;
    int          s_cyc, lat;
    logic        mdone, mbusy;

    assign mdone = started && (cyc >= s_cyc + lat);
    assign mbusy = started && (cyc >= s_cyc) && !mdone;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ea_q.delete();
        ed_q.delete();
        er_q.delete();
        started <= 1'b0;
        s_cyc   <= 0;
        lat     <= 0;
      end else if (start && !started) begin
        started <= 1'b1;
        s_cyc   <= cyc + 1;
        lat     <= lat_of(W);
        for (int i = 0; i < W; i++) begin
          ea_q.push_back(BASE + 32'(4 * i));
          ed_q.push_back(rom_mem[i]);
          er_q.push_back(i);
        end
      end
    end

    // Monitor
    logic        p_rom_ack, p_ram_stb, p_ram_ack;
    logic [31:0] p_ram_adr, p_ram_dat;

    always @(negedge clk) begin
      if (!rst_n) begin
        p_rom_ack <= 1'b0;
        p_ram_stb <= 1'b0;
        p_ram_ack <= 1'b0;
      end else begin
        chk($sformatf("i%0d.done", g), done, mdone);
        chk($sformatf("i%0d.cpu_hold", g), hold, !mdone);
        chk($sformatf("i%0d.busy", g), busy, mbusy);
        if (!mbusy)
          chk($sformatf("i%0d.quiet_bus", g), {rom_cyc, rom_stb, ram_cyc, ram_stb}, 0);
        chk($sformatf("i%0d.strobe_overlap", g), rom_stb & ram_stb, 0);
        chk($sformatf("i%0d.rom_stb_after_ack", g), rom_stb & p_rom_ack, 0);
        if (rom_stb && rom_ack) begin
          if (er_q.size() == 0) chk($sformatf("i%0d.unexpected_rom_read", g), 1, 0);
          else chk($sformatf("i%0d.rom_adr", g), rom_adr, er_q.pop_front());
          chk($sformatf("i%0d.rom_cyc", g), rom_cyc, 1);
        end
        if (ram_stb && ram_ack) begin
          if (ea_q.size() == 0) chk($sformatf("i%0d.unexpected_ram_write", g), 1, 0);
          else begin
            chk($sformatf("i%0d.ram_adr", g), ram_adr, ea_q.pop_front());
            chk($sformatf("i%0d.ram_dat", g), ram_dat, ed_q.pop_front());
          end
          chk($sformatf("i%0d.ram_cyc_we_sel", g), {ram_cyc, ram_we, ram_sel}, 6'h3F);
        end
        if (ram_stb && p_ram_stb && !p_ram_ack)
          chk($sformatf("i%0d.ram_hold_steady", g), {ram_adr, ram_dat}, {p_ram_adr, p_ram_dat});
        p_rom_ack <= rom_ack;
        p_ram_stb <= ram_stb;
        p_ram_ack <= ram_ack;
        p_ram_adr <= ram_adr;
        p_ram_dat <= ram_dat;
      end
    end
  end

  task automatic check_reset();
    chk("i0.rst_strobes", {gi[0].rom_cyc, gi[0].rom_stb, gi[0].ram_cyc, gi[0].ram_stb, gi[0].ram_we}, 0);
    chk("i0.rst_adr", {gi[0].rom_adr, gi[0].ram_adr}, 0);
    chk("i0.rst_dat_sel", {gi[0].ram_dat, gi[0].ram_sel}, 0);
    chk("i0.rst_status", {gi[0].busy, gi[0].done, gi[0].hold}, 3'b001);
    chk("i1.rst_strobes", {gi[1].rom_cyc, gi[1].rom_stb, gi[1].ram_cyc, gi[1].ram_stb, gi[1].ram_we}, 0);
    chk("i1.rst_adr", {gi[1].rom_adr, gi[1].ram_adr}, {1'b0, 32'h8000_0000});
    chk("i1.rst_dat_sel", {gi[1].ram_dat, gi[1].ram_sel}, 0);
    chk("i1.rst_status", {gi[1].busy, gi[1].done, gi[1].hold}, 3'b001);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gi[0].done && gi[1].done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_within_budget", ok, 1);
    chk("all_writes_seen", gi[0].ea_q.size() + gi[1].ea_q.size() + gi[0].er_q.size() + gi[1].er_q.size(), 0);
  endtask

  task automatic randomize_image();
    for (int i = 0; i < 4; i++) begin
      rom_mem[i] = $urandom;
      ram_dly[i] = $urandom_range(1, 3);
    end
  endtask

  initial begin
    bit hit;
    rst_n    = 1'b0;
    start    = 1'b0;
    spur_rom = 1'b0;
    spur_ram = 1'b0;
    rom_mem  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    ram_dly  = '{1, 1, 1, 1};
    repeat (2) @(posedge clk);
    #1 check_reset();
    rst_n = 1'b1;

    // Fixed image, single-cycle RAM acks: 16-cycle copy on the 4-word instance
    pulse_start();
    wait_done();

    // Stray acks and start while done
    @(posedge clk);
    #1 begin spur_rom = 1'b1; start = 1'b1; end
    repeat (3) @(posedge clk);
    #1 begin spur_rom = 1'b0; spur_ram = 1'b1; end
    repeat (3) @(posedge clk);
    #1 begin spur_ram = 1'b0; start = 1'b0; end
    repeat (3) @(posedge clk);

    // Stray acks while idle, then word 1 gets a 5-cycle RAM ack
    do_reset();
    @(posedge clk);
    #1 begin spur_rom = 1'b1; spur_ram = 1'b1; end
    repeat (4) @(posedge clk);
    #1 begin spur_rom = 1'b0; spur_ram = 1'b0; end
    repeat (3) @(posedge clk);
    randomize_image();
    ram_dly = '{1, 5, 1, 1};
    pulse_start();
    wait_done();

    // Reset during the write of word 2, then restart from word 0
    do_reset();
    randomize_image();
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gi[0].ram_stb && gi[0].ram_adr == 32'h8) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_word2_write", hit, 1);
    do_reset();
    randomize_image();
    pulse_start();
    wait_done();

    // Random images and RAM latencies
    for (int r = 0; r < 3; r++) begin
      do_reset();
      randomize_image();
      pulse_start();
      wait_done();
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
